v_display_rx: RTL and testbench
===============================

V_DISPLAY_RX -- requirements
Module: v_display_rx

Interface
REQ-001 SHALL have parameter INTERFACE_RX_CHUNK_TYPE, default 6, chunk type byte that selects display-write frames.
REQ-002 SHALL have parameter DISPLAY_BUFFER_BYTE_SIZE, default 64, display size in bytes.
REQ-003 SHALL have parameter DISPLAY_BUFFER_INDEX_SIZE, default 8, width of the byte index.
REQ-004 SHALL have parameter FRAME_TIMEOUT_CYCLES, default 1000000, cycles allowed between bytes of one frame.
REQ-005 CLK  input  1  single system clock; all logic on posedge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 rx_valid  input  1  rx_byte holds a received UART byte this cycle.
REQ-008 rx_byte  input  8  received byte.
REQ-009 rx_ready  output  1  block accepts a byte; a byte transfers when rx_valid and rx_ready are both 1.
REQ-010 display  output  DISPLAY_BUFFER_BYTE_SIZE*8  current display buffer; byte i is display[i*8 +: 8].
REQ-011 display_updated  output  1  one-cycle pulse after a committed write changed a byte.
REQ-012 drop_count  output  8  saturating count of discarded frames (bad index or timeout).

Function
REQ-013 Frame format SHALL be 3 bytes: type, index, value (the same layout the display transmitter sends: index low byte, value high byte).
REQ-014 States SHALL be IDLE, GET_INDEX, GET_VALUE, SKIP1, SKIP2, COMMIT.
REQ-015 IDLE: accepted byte equal to INTERFACE_RX_CHUNK_TYPE -> GET_INDEX; any other accepted byte -> SKIP1.
REQ-016 GET_INDEX: accepted byte latched as index -> GET_VALUE.
REQ-017 GET_VALUE: accepted byte latched as value -> COMMIT.
REQ-018 SKIP1 -> SKIP2 -> IDLE, one accepted byte each, bytes discarded, drop_count unchanged.
REQ-019 COMMIT: lasts exactly one cycle, rx_ready=0; if index < DISPLAY_BUFFER_BYTE_SIZE, write value to byte index; then -> IDLE.
REQ-020 Index >= DISPLAY_BUFFER_BYTE_SIZE SHALL leave display unchanged and increment drop_count.
REQ-021 display_updated SHALL pulse the cycle after COMMIT only if the written value differs from the old byte; rewriting an identical value gives no pulse.
REQ-022 rx_ready SHALL be 1 in every state except COMMIT; bytes with rx_valid=1 during COMMIT are not consumed (producer holds them).
REQ-023 Latency: display reflects a frame one cycle after the value byte is accepted.
REQ-024 Timeout counter SHALL clear on each accepted byte and in IDLE; in GET_INDEX, GET_VALUE, SKIP1 or SKIP2 reaching FRAME_TIMEOUT_CYCLES idle cycles -> IDLE, partial frame discarded, drop_count increments.
REQ-025 drop_count SHALL saturate at 255, never wrap.
REQ-026 Timeout and byte acceptance in the same cycle: byte acceptance wins, no drop counted.

Reset
REQ-027 RST_N low SHALL immediately force: state IDLE, display all zeros, display_updated 0, drop_count 0, timeout counter 0, rx_ready 0 while asserted.
REQ-028 Reset mid-frame SHALL discard the partial frame without counting it; first byte after release is parsed as a type byte.

Structure
REQ-029 Chunk type constants (RX and TX display types) and frame length SHALL live in the shared interface constants include used by all chunk modules.
REQ-030 Byte framing (REQ-014..018, REQ-024) SHALL be a sub-module rx_chunk_parser emitting chunk_valid, chunk_type, chunk_bytes[15:0], chunk_timeout; v_display_rx SHALL own buffer, compare and counters.

Verification
REQ-031 Send 06 05 AB -> display byte 5 = 0xAB one cycle after last byte, display_updated pulses once, all other bytes 0.
REQ-032 Send 06 05 AB twice -> second frame gives no display_updated pulse, display unchanged.
REQ-033 Send 07 05 AB then 06 01 11 -> byte 5 stays 0, byte 1 = 0x11, drop_count 0.
REQ-034 Send 06 40 FF (index 64) -> display unchanged, drop_count 1; repeat 300 times -> drop_count 255.
REQ-035 Send 06 05, stall FRAME_TIMEOUT_CYCLES (set 16) -> IDLE, drop_count 1; then 06 02 22 -> byte 2 = 0x22.
REQ-036 Send 06 05 then pulse RST_N low -> display zeros, drop_count 0; then 06 03 33 -> byte 3 = 0x33.

Source files
------------

// File: rtl/v_display_rx_pkg.sv
// Shared chunk-interface constants and the display receiver's frame states.
// Imported by every chunk module so the type bytes and frame length agree on both ends.
package v_display_rx_pkg;

  localparam logic [7:0] CHUNK_TYPE_DISPLAY_RX = 8'd6;
  localparam logic [7:0] CHUNK_TYPE_DISPLAY_TX = 8'd5;
  localparam int         CHUNK_FRAME_LEN       = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_INDEX = 3'd1,
    ST_GET_VALUE = 3'd2,
    ST_SKIP1     = 3'd3,
    ST_SKIP2     = 3'd4,
    ST_COMMIT    = 3'd5
  } rx_state_e;

  // Successor of a mid-frame state once its byte has been accepted.
  function automatic rx_state_e next_on_byte(input rx_state_e st);
    case (st)
      ST_GET_INDEX: next_on_byte = ST_GET_VALUE;
      ST_GET_VALUE: next_on_byte = ST_COMMIT;
      ST_SKIP1:     next_on_byte = ST_SKIP2;
      ST_SKIP2:     next_on_byte = ST_IDLE;
      default:      next_on_byte = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rx_chunk_parser.sv
// Splits the UART byte stream into 3-byte chunks, skipping foreign chunks and
// abandoning any frame whose bytes stall longer than TIMEOUT_CYCLES.
module rx_chunk_parser
  import v_display_rx_pkg::*;
#(
  parameter int CHUNK_TYPE     = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        chunk_valid,
  output logic [7:0]  chunk_type,
  output logic [15:0] chunk_bytes,
  output logic        chunk_timeout
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    TYPE_BYTE = 8'(CHUNK_TYPE);

  rx_state_e     state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [7:0]    type_r, index_r, value_r;
  logic          accept_s;

  // Ready is forced low while reset is held, not just after the first edge.
  assign rx_ready    = RST_N && (state_r != ST_COMMIT);
  assign accept_s    = rx_valid && rx_ready;
  assign chunk_valid = (state_r == ST_COMMIT);
  assign chunk_type  = type_r;
  assign chunk_bytes = {value_r, index_r};

  // Next-state and inter-byte timeout; an accepted byte always beats the timeout.
  always_comb begin
    state_s       = state_r;
    timer_s       = '0;
    chunk_timeout = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = (rx_byte == TYPE_BYTE) ? ST_GET_INDEX : ST_SKIP1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GET_INDEX, ST_GET_VALUE, ST_SKIP1, ST_SKIP2: begin
        if (accept_s) begin
          state_s = next_on_byte(state_r);
        end else if (timer_r == TMO_LAST) begin
          state_s       = ST_IDLE;
          chunk_timeout = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, timer and frame field registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      type_r  <= 8'd0;
      index_r <= 8'd0;
      value_r <= 8'd0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      if (accept_s && state_r == ST_IDLE)      type_r  <= rx_byte;
      if (accept_s && state_r == ST_GET_INDEX) index_r <= rx_byte;
      if (accept_s && state_r == ST_GET_VALUE) value_r <= rx_byte;
    end
  end

endmodule

// File: rtl/v_display_rx.sv
// Display-write receiver: applies (index, value) chunks to the display buffer,
// flags real changes and counts discarded frames.
module v_display_rx
  import v_display_rx_pkg::*;
#(
  parameter int INTERFACE_RX_CHUNK_TYPE   = int'(CHUNK_TYPE_DISPLAY_RX),
  parameter int DISPLAY_BUFFER_BYTE_SIZE  = 64,
  parameter int DISPLAY_BUFFER_INDEX_SIZE = 8,
  parameter int FRAME_TIMEOUT_CYCLES      = 1000000
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  rx_valid,
  input  logic [7:0]                            rx_byte,
  output logic                                  rx_ready,
  output logic [DISPLAY_BUFFER_BYTE_SIZE*8-1:0] display,
  output logic                                  display_updated,
  output logic [7:0]                            drop_count
);

  localparam int         DW      = DISPLAY_BUFFER_BYTE_SIZE * 8;
  localparam int         IW      = DISPLAY_BUFFER_INDEX_SIZE;
  localparam logic [7:0] RX_TYPE = 8'(INTERFACE_RX_CHUNK_TYPE);

  logic          chunk_valid_s, chunk_timeout_s;
  logic [7:0]    chunk_type_s;
  logic [15:0]   chunk_bytes_s;
  logic [7:0]    index_raw_s, value_s;
  logic [IW-1:0] index_s;
  logic          in_range_s, commit_s, changed_s, drop_s;
  logic [DW-1:0] display_r, display_s;
  logic          display_updated_r;
  logic [7:0]    drop_count_r;

  rx_chunk_parser #(
    .CHUNK_TYPE     (INTERFACE_RX_CHUNK_TYPE),
    .TIMEOUT_CYCLES (FRAME_TIMEOUT_CYCLES)
  ) u_parser (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .rx_ready      (rx_ready),
    .chunk_valid   (chunk_valid_s),
    .chunk_type    (chunk_type_s),
    .chunk_bytes   (chunk_bytes_s),
    .chunk_timeout (chunk_timeout_s)
  );

  assign index_raw_s = chunk_bytes_s[7:0];
  assign value_s     = chunk_bytes_s[15:8];
  assign index_s     = IW'(index_raw_s);
  assign in_range_s  = (32'(index_raw_s) < 32'(DISPLAY_BUFFER_BYTE_SIZE));
  assign commit_s    = chunk_valid_s && (chunk_type_s == RX_TYPE);
  assign drop_s      = (commit_s && !in_range_s) || chunk_timeout_s;

  // Buffer write and old-versus-new byte compare for the committed chunk.
  always_comb begin
    display_s = display_r;
    changed_s = 1'b0;
    if (commit_s && in_range_s) begin
      for (int i = 0; i < DISPLAY_BUFFER_BYTE_SIZE; i++) begin
        if (index_s == IW'(i)) begin
          changed_s           = (display_r[i*8 +: 8] != value_s);
          display_s[i*8 +: 8] = value_s;
        end else begin
          display_s[i*8 +: 8] = display_r[i*8 +: 8];
        end
      end
    end else begin
      display_s = display_r;
    end
  end

  // Display buffer, update pulse and saturating drop counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      display_r         <= '0;
      display_updated_r <= 1'b0;
      drop_count_r      <= 8'd0;
    end else begin
      display_r         <= display_s;
      display_updated_r <= changed_s;
      if (drop_s && drop_count_r != 8'hFF) drop_count_r <= drop_count_r + 8'd1;
    end
  end

  assign display         = display_r;
  assign display_updated = display_updated_r;
  assign drop_count      = drop_count_r;

endmodule

// File: tb/tb_v_display_rx.sv
// Directed bench for v_display_rx: a frame-level model of the display buffer and
// drop counter is compared against the DUT on every falling clock edge.
module tb_v_display_rx;

  localparam int NB  = 64;
  localparam int TMO = 16;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            rx_ready;
  logic [NB*8-1:0] display;
  logic            display_updated;
  logic [7:0]      drop_count;

  logic [7:0] exp_disp [NB];
  int         exp_drop;
  int         upd_cyc;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  v_display_rx #(
    .INTERFACE_RX_CHUNK_TYPE   (6),
    .DISPLAY_BUFFER_BYTE_SIZE  (NB),
    .DISPLAY_BUFFER_INDEX_SIZE (8),
    .FRAME_TIMEOUT_CYCLES      (TMO)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .rx_valid        (rx_valid),
    .rx_byte         (rx_byte),
    .rx_ready        (rx_ready),
    .display         (display),
    .display_updated (display_updated),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) exp_disp[k] = 8'h00;
    exp_drop = 0;
    upd_cyc  = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_byte  = b;
    n = 0;
    while (!rx_ready && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  // gap = idle cycles inserted before the value byte
  task automatic send_frame(input logic [7:0] t, input logic [7:0] i, input logic [7:0] v, input int gap);
    send_byte(t);
    send_byte(i);
    repeat (gap) @(posedge CLK);
    send_byte(v);
    if (t == 8'h06) begin
      check("commit_ready_low", {31'd0, rx_ready}, 32'd0);
      @(posedge CLK);
      #1;
      if (int'(i) < NB) begin
        if (exp_disp[i] != v) upd_cyc = cyc;
        exp_disp[i] = v;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    model_reset();
    fork
      begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ready_low", {31'd0, rx_ready}, 32'd0);
        check("reset_drop", {24'd0, drop_count}, 32'd0);
        check("reset_display", {31'd0, |display}, 32'd0);
        RST_N = 1'b1;

        // single write
        send_frame(8'h06, 8'h05, 8'hAB, 0);
        check("byte5_ab", {24'd0, display[5*8 +: 8]}, 32'hAB);
        check("model_byte5", {24'd0, exp_disp[5]}, 32'hAB);
        // identical rewrite
        send_frame(8'h06, 8'h05, 8'hAB, 0);
        // foreign chunk skipped, then a real one
        send_frame(8'h07, 8'h05, 8'hCD, 0);
        send_frame(8'h06, 8'h01, 8'h11, 0);
        check("byte5_kept", {24'd0, display[5*8 +: 8]}, 32'hAB);
        check("byte1_11", {24'd0, display[1*8 +: 8]}, 32'h11);
        check("drop_zero", {24'd0, drop_count}, 32'd0);
        // top index
        send_frame(8'h06, 8'h3F, 8'h5A, 0);
        check("byte63_5a", {24'd0, display[63*8 +: 8]}, 32'h5A);

        // timeout mid-frame
        send_byte(8'h06);
        send_byte(8'h05);
        repeat (TMO) @(posedge CLK);
        #1;
        exp_drop++;
        check("drop_timeout", {24'd0, drop_count}, 32'd1);
        send_frame(8'h06, 8'h02, 8'h22, 0);
        check("byte2_22", {24'd0, display[2*8 +: 8]}, 32'h22);
        // byte on the last allowed cycle still counts
        send_frame(8'h06, 8'h07, 8'h77, TMO - 1);
        check("byte7_77", {24'd0, display[7*8 +: 8]}, 32'h77);
        check("drop_boundary", {24'd0, drop_count}, 32'd1);
        // timeout while skipping a foreign chunk
        send_byte(8'h09);
        repeat (TMO) @(posedge CLK);
        #1;
        exp_drop++;
        check("drop_skip_timeout", {24'd0, drop_count}, 32'd2);

        // reset mid-frame
        send_byte(8'h06);
        send_byte(8'h05);
        RST_N = 1'b0;
        model_reset();
        #1;
        check("midrst_ready_low", {31'd0, rx_ready}, 32'd0);
        check("midrst_display", {31'd0, |display}, 32'd0);
        check("midrst_drop", {24'd0, drop_count}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        send_frame(8'h06, 8'h03, 8'h33, 0);
        check("byte3_33", {24'd0, display[3*8 +: 8]}, 32'h33);

        // out-of-range index and saturation
        send_frame(8'h06, 8'h40, 8'hFF, 0);
        check("drop_badidx", {24'd0, drop_count}, 32'd1);
        for (int n = 1; n < 300; n++) send_frame(8'h06, 8'h40, 8'hFF, 0);
        check("drop_saturated", {24'd0, drop_count}, 32'd255);
        check("model_drop_sat", exp_drop, 32'd255);
        repeat (2) @(posedge CLK);
      end
      begin
        logic [NB*8-1:0] ev;
        forever begin
          @(negedge CLK);
          for (int k = 0; k < NB; k++) ev[k*8 +: 8] = exp_disp[k];
          tests++;
          if (display !== ev) begin
            fails++;
            $display("FAIL display got %h want %h", display, ev);
          end
          check("display_updated", {31'd0, display_updated}, (cyc == upd_cyc) ? 32'd1 : 32'd0);
          check("drop_count", {24'd0, drop_count}, exp_drop);
        end
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
